// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - client and server bus bundle for bus_arbiter
interface bus_arbiter_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4
);
    localparam int GW = $clog2(NUM_CLIENTS);

    logic [NUM_CLIENTS-1:0]            rq;
    logic [NUM_CLIENTS*ADDR_WIDTH-1:0] address;
    logic [NUM_CLIENTS-1:0]            wr_ni;
    logic [NUM_CLIENTS*DATA_WIDTH-1:0] dataW;
    logic [NUM_CLIENTS-1:0]            ack;
    logic [DATA_WIDTH-1:0]             dataR;
    logic                              err;
    logic                              srv_rq;
    logic [ADDR_WIDTH-1:0]             srv_addr;
    logic                              srv_wr_ni;
    logic [DATA_WIDTH-1:0]             srv_dataW;
    logic                              srv_ack;
    logic [DATA_WIDTH-1:0]             srv_dataR;
    logic [GW-1:0]                     grant;
    logic                              busy;

    modport slave (
        input  rq, address, wr_ni, dataW, srv_ack, srv_dataR,
        output ack, dataR, err, srv_rq, srv_addr, srv_wr_ni, srv_dataW, grant, busy
    );

    modport master (
        output rq, address, wr_ni, dataW, srv_ack, srv_dataR,
        input  ack, dataR, err, srv_rq, srv_addr, srv_wr_ni, srv_dataW, grant, busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter granting one client at a time to a single server
module bus_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_CLIENTS);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state, state_nxt;
    logic [GW-1:0]          grant_r, ptr_r, winner, grant_inc;
    logic                   win_valid;
    logic [CW-1:0]          cnt_r;
    logic                   err_flag_r;
    logic [DATA_WIDTH-1:0]  data_r;
    logic [NUM_CLIENTS-1:0] mask_r, eligible, ack_c;
    logic [GW:0]            sum;
    logic [GW-1:0]          idx;
    logic                   timed_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Search starts at ptr and wraps; the client just served is masked for one IDLE cycle
    always_comb begin
        winner    = '0;
        win_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        eligible  = bus.rq & ~mask_r;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            sum = {1'b0, ptr_r} + (GW+1)'(i);
            if (sum >= (GW+1)'(NUM_CLIENTS)) sum = sum - (GW+1)'(NUM_CLIENTS);
            idx = sum[GW-1:0];
            if (!win_valid && eligible[idx]) begin
                win_valid = 1'b1;
                winner    = idx;
            end
        end
    end

    assign grant_inc = (grant_r == GW'(NUM_CLIENTS-1)) ? '0 : grant_r + GW'(1);
    assign timed_out = (cnt_r == CW'(TIMEOUT-1));

    always_comb begin
        state_nxt = state;
        ack_c     = '0;
        case (state)
            IDLE: if (win_valid) state_nxt = BUSY;
            BUSY: if (bus.srv_ack || timed_out) state_nxt = DONE;
            DONE: begin
                ack_c     = NUM_CLIENTS'(1) << grant_r;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r      <= '0;
            grant_r    <= '0;
            cnt_r      <= '0;
            err_flag_r <= 1'b0;
            data_r     <= '0;
            mask_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mask_r <= '0;
                    if (win_valid) begin
                        grant_r    <= winner;
                        cnt_r      <= '0;
                        err_flag_r <= 1'b0;
                    end
                end
                BUSY: begin
                    // A completion arriving on the expiry cycle still counts as a good transfer
                    if (bus.srv_ack) begin
                        data_r     <= bus.srv_dataR;
                        cnt_r      <= '0;
                        err_flag_r <= 1'b0;
                    end else if (timed_out) begin
                        data_r     <= '0;
                        cnt_r      <= '0;
                        err_flag_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    ptr_r  <= grant_inc;
                    mask_r <= NUM_CLIENTS'(1) << grant_r;
                end
                default: ;
            endcase
        end
    end

    assign bus.ack       = ack_c;
    assign bus.err       = (state == DONE) && err_flag_r;
    assign bus.dataR     = data_r;
    assign bus.srv_rq    = (state == BUSY);
    assign bus.busy      = (state != IDLE);
    assign bus.grant     = grant_r;
    assign bus.srv_addr  = bus.address[grant_r*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.srv_wr_ni = bus.wr_ni[grant_r];
    assign bus.srv_dataW = bus.dataW[grant_r*DATA_WIDTH +: DATA_WIDTH];
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;
    localparam int NC = 4;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_CLIENTS(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bus_arbiter #(.NUM_CLIENTS(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW-1:0] addr_tab [NC] = '{4'h9, 4'h3, 4'h5, 4'hC};
    logic          wr_tab   [NC] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [DW-1:0] data_tab [NC] = '{8'h1A, 8'h2B, 8'h3C, 8'hD3};
    int            fair_tab [4]  = '{0, 3, 0, 3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the grant to client g, completes it after 'delay' extra BUSY cycles
    task automatic xfer(input string tag, input int g, input int delay, input logic [7:0] rd, input bit drop);
        int n = 0;
        while (!bus.srv_rq && n < 4) begin
            tick();
            n++;
        end
        check($sformatf("%s_srv_rq", tag), bus.srv_rq, 1);
        check($sformatf("%s_grant", tag), bus.grant, g);
        check($sformatf("%s_addr", tag), bus.srv_addr, addr_tab[g]);
        check($sformatf("%s_wr_ni", tag), bus.srv_wr_ni, wr_tab[g]);
        check($sformatf("%s_dataW", tag), bus.srv_dataW, data_tab[g]);
        repeat (delay) tick();
        check($sformatf("%s_wait", tag), {bus.srv_rq, bus.ack}, 5'b10000);
        bus.srv_ack   = 1'b1;
        bus.srv_dataR = rd;
        tick();
        bus.srv_ack   = 1'b0;
        bus.srv_dataR = '0;
        check($sformatf("%s_ack", tag), bus.ack, 32'(1) << g);
        check($sformatf("%s_dataR", tag), bus.dataR, rd);
        check($sformatf("%s_done", tag), {bus.err, bus.srv_rq, bus.busy}, 3'b001);
        if (drop) bus.rq[g] = 1'b0;
        tick();
        check($sformatf("%s_ack_end", tag), {bus.ack, bus.busy}, 5'b00000);
        check($sformatf("%s_hold", tag), bus.dataR, rd);
    endtask

    initial begin
        bit ok;
        bus.rq        = '0;
        bus.address   = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
        bus.wr_ni     = {wr_tab[3], wr_tab[2], wr_tab[1], wr_tab[0]};
        bus.dataW     = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};
        bus.srv_ack   = 1'b0;
        bus.srv_dataR = '0;
        repeat (2) tick();
        check("rst_outs", {bus.ack, bus.err, bus.srv_rq, bus.busy}, 7'b0);
        check("rst_grant", bus.grant, 0);
        check("rst_dataR", bus.dataR, 0);
        check("rst_mux", {bus.srv_addr, bus.srv_wr_ni, bus.srv_dataW}, {4'h9, 1'b0, 8'h1A});
        reset = 1'b0;
        tick();

        bus.srv_ack   = 1'b1;
        bus.srv_dataR = 8'hEE;
        tick();
        bus.srv_ack   = 1'b0;
        tick();
        check("idle_ack_ignored", {bus.ack, bus.busy, bus.dataR}, 13'b0);

        bus.rq = 4'b0100;
        xfer("single", 2, 2, 8'hA5, 1);

        bus.rq = 4'b0010;
        tick();
        check("mr_busy", {bus.srv_rq, bus.grant}, 3'b101);
        tick();
        reset = 1'b1;
        #1;
        check("mr_async", {bus.ack, bus.srv_rq, bus.busy, bus.grant}, 8'b0);
        check("mr_addr", bus.srv_addr, 4'h9);
        tick();
        reset         = 1'b0;
        bus.rq        = '0;
        bus.srv_ack   = 1'b1;
        bus.srv_dataR = 8'h77;
        tick();
        bus.srv_ack   = 1'b0;
        check("mr_late_ack", {bus.ack, bus.busy, bus.dataR}, 13'b0);
        tick();
        check("mr_idle", {bus.ack, bus.busy, bus.grant}, 7'b0);

        bus.rq = 4'b1111;
        for (int g = 0; g < NC; g++) xfer($sformatf("rr%0d", g), g, 1, 8'h10 + 8'(g), 1);
        bus.rq = '0;
        tick();

        bus.rq = 4'b1001;
        for (int k = 0; k < 4; k++) xfer($sformatf("fair%0d", k), fair_tab[k], 0, 8'h40 + 8'(k), 0);
        bus.rq = '0;
        tick();

        bus.rq = 4'b0001;
        xfer("solo", 0, 1, 8'h66, 0);
        check("solo_masked", bus.srv_rq, 0);
        tick();
        check("solo_unmask_idle", bus.srv_rq, 0);
        tick();
        check("solo_reserve", {bus.srv_rq, bus.grant}, 3'b100);
        bus.srv_ack   = 1'b1;
        bus.srv_dataR = 8'h99;
        tick();
        bus.srv_ack   = 1'b0;
        bus.rq        = '0;
        check("solo_ack2", {bus.ack, bus.dataR}, {4'b0001, 8'h99});
        tick();

        bus.rq = 4'b0010;
        tick();
        check("to_grant", {bus.srv_rq, bus.grant}, 3'b101);
        ok = 1'b1;
        for (int i = 0; i < TO; i++) begin
            if (!bus.srv_rq || bus.ack != 0) ok = 1'b0;
            tick();
        end
        check("to_wait16", ok, 1);
        check("to_done", {bus.ack, bus.err, bus.dataR}, {4'b0010, 1'b1, 8'h00});
        bus.rq = '0;
        tick();
        check("to_after", {bus.ack, bus.err, bus.busy}, 6'b0);

        bus.rq = 4'b1011;
        xfer("bnd", 3, TO - 1, 8'h5A, 1);
        bus.rq = '0;
        tick();
        check("end_idle", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
